bs_tx_arbiter: RTL and testbench

BS_TX_ARBITER -- requirements
Module: bs_tx_arbiter

---
 rtl/bs_arb_pkg.sv | 25 ++
 rtl/bs_arb_rr_pick.sv | 18 +
 rtl/bs_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_bs_tx_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_arb_pkg.sv
// Shared types and defaults for the bit-stuffer transmit arbiter.
// Build option BS_ARB_WATCHDOG_EN (in bs_tx_arbiter) enables the start watchdog.
package bs_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      STREAM,
      DRAIN,
      GAP
   } arb_state_t;

   typedef enum logic {
      SRC_TOK,
      SRC_DAT
   } src_t;

   localparam int GAP_CYCLES_DEF    = 2;
   localparam int START_TIMEOUT_DEF = 16;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/bs_arb_rr_pick.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to
// the source that did not win last time.
module bs_arb_rr_pick
   import bs_arb_pkg::*;
(
   input  logic i_tok_req,
   input  logic i_dat_req,
   input  src_t i_last_winner,
   output logic o_win_tok,
   output logic o_win_dat
);

   always_comb begin
      o_win_tok = i_tok_req & (~i_dat_req | (i_last_winner == SRC_DAT));
      o_win_dat = i_dat_req & ~o_win_tok;
   end

endmodule

// File: rtl/bs_tx_arbiter.sv
// Arbitrates token (CRC5) and data (CRC16) bit streams onto a shared stuffing encoder.
// Define BS_ARB_WATCHDOG_EN to abort a grant whose source never starts streaming.
//
// state  | meaning
// IDLE   | no grant, arbitrating requests
// GRANT  | grant held, waiting for first valid bit
// STREAM | granted bits passing through to the encoder
// DRAIN  | stream ended, waiting for encoder to stop sending
// GAP    | grants low for GAP_CYCLES before re-arbitrating
module bs_tx_arbiter
   import bs_arb_pkg::*;
#(
   parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
   parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic tok_req,
   input  logic dat_req,
   input  logic tok_valid,
   input  logic tok_bit,
   input  logic dat_valid,
   input  logic dat_bit,
   input  logic bs_ready,
   input  logic bs_sending,
   output logic tok_gnt,
   output logic dat_gnt,
   output logic tok_ready,
   output logic dat_ready,
   output logic enc5_valid,
   output logic enc5_bit,
   output logic enc16_valid,
   output logic enc16_bit,
   output logic busy,
   output logic timeout_err
);

   localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
   localparam logic [7:0] TO_LAST  = (START_TIMEOUT > 0) ? 8'(START_TIMEOUT - 1) : 8'd0;

   arb_state_t r_state;
   src_t       r_last_winner;
   logic       r_gnt_tok;
   logic       r_gnt_dat;
   logic [7:0] r_gap_cnt;
   logic [7:0] r_to_cnt;
`ifdef BS_ARB_WATCHDOG_EN
   logic       r_timeout_err;
`endif

   logic w_win_tok;
   logic w_win_dat;
   logic w_valid_g;
   logic w_req_g;
   logic w_fwd;

   bs_arb_rr_pick u_pick (
      .i_tok_req     (tok_req),
      .i_dat_req     (dat_req),
      .i_last_winner (r_last_winner),
      .o_win_tok     (w_win_tok),
      .o_win_dat     (w_win_dat)
   );

   assign w_valid_g = (r_gnt_tok & tok_valid) | (r_gnt_dat & dat_valid);
   assign w_req_g   = (r_gnt_tok & tok_req)   | (r_gnt_dat & dat_req);
   // Once draining, the source is done; anything it presents is not forwarded.
   assign w_fwd     = (r_state != DRAIN);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_last_winner <= SRC_DAT;
         r_gnt_tok     <= 1'b0;
         r_gnt_dat     <= 1'b0;
         r_gap_cnt     <= 8'd0;
         r_to_cnt      <= 8'd0;
`ifdef BS_ARB_WATCHDOG_EN
         r_timeout_err <= 1'b0;
`endif
      end else begin
`ifdef BS_ARB_WATCHDOG_EN
         r_timeout_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_win_tok | w_win_dat) begin
                  r_gnt_tok     <= w_win_tok;
                  r_gnt_dat     <= w_win_dat;
                  r_last_winner <= w_win_dat ? SRC_DAT : SRC_TOK;
                  r_to_cnt      <= 8'd0;
                  r_state       <= GRANT;
               end
            end
            GRANT: begin
               if (w_valid_g) begin
                  r_state <= STREAM;
               end else if (!w_req_g) begin
                  r_gnt_tok <= 1'b0;
                  r_gnt_dat <= 1'b0;
                  r_state   <= IDLE;
`ifdef BS_ARB_WATCHDOG_EN
               end else if (r_to_cnt == TO_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_gnt_tok     <= 1'b0;
                  r_gnt_dat     <= 1'b0;
                  r_gap_cnt     <= 8'd0;
                  r_state       <= (GAP_CYCLES == 0) ? IDLE : GAP;
`endif
               end else if (r_to_cnt != TO_LAST) begin
                  r_to_cnt <= sat_inc8(r_to_cnt);
               end
            end
            STREAM: begin
               if (!w_valid_g) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!bs_sending) begin
                  r_gnt_tok <= 1'b0;
                  r_gnt_dat <= 1'b0;
                  r_gap_cnt <= 8'd0;
                  r_state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end
            end
            GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= IDLE;
               end else begin
                  r_gap_cnt <= sat_inc8(r_gap_cnt);
               end
            end
            default: begin
               r_gnt_tok <= 1'b0;
               r_gnt_dat <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign tok_gnt     = r_gnt_tok;
   assign dat_gnt     = r_gnt_dat;
   assign tok_ready   = r_gnt_tok & bs_ready;
   assign dat_ready   = r_gnt_dat & bs_ready;
   assign enc5_valid  = r_gnt_tok & tok_valid & w_fwd;
   assign enc5_bit    = r_gnt_tok & tok_bit;
   assign enc16_valid = r_gnt_dat & dat_valid & w_fwd;
   assign enc16_bit   = r_gnt_dat & dat_bit;
   assign busy        = (r_state != IDLE);

`ifdef BS_ARB_WATCHDOG_EN
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bs_tx_arbiter.sv
// Self-checking bench for bs_tx_arbiter: directed scenarios plus randomized
// packets checked against a transaction-level arbitration/pass-through model.
module tb_bs_tx_arbiter;

   localparam int G = 2;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic tok_req = 1'b0, dat_req = 1'b0;
   logic tok_valid = 1'b0, tok_bit = 1'b0;
   logic dat_valid = 1'b0, dat_bit = 1'b0;
   logic bs_ready = 1'b0, bs_sending = 1'b0;

   logic tok_gnt, dat_gnt, tok_ready, dat_ready;
   logic enc5_valid, enc5_bit, enc16_valid, enc16_bit, busy, timeout_err;

   logic tok_gnt_z, dat_gnt_z, tok_ready_z, dat_ready_z;
   logic enc5_valid_z, enc5_bit_z, enc16_valid_z, enc16_bit_z, busy_z, timeout_err_z;

   int errors = 0;
   int checks = 0;
   int lw_model = 1;  // 0 = token won last, 1 = data won last

   bs_tx_arbiter #(.GAP_CYCLES(G), .START_TIMEOUT(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .tok_req(tok_req), .dat_req(dat_req),
      .tok_valid(tok_valid), .tok_bit(tok_bit),
      .dat_valid(dat_valid), .dat_bit(dat_bit),
      .bs_ready(bs_ready), .bs_sending(bs_sending),
      .tok_gnt(tok_gnt), .dat_gnt(dat_gnt),
      .tok_ready(tok_ready), .dat_ready(dat_ready),
      .enc5_valid(enc5_valid), .enc5_bit(enc5_bit),
      .enc16_valid(enc16_valid), .enc16_bit(enc16_bit),
      .busy(busy), .timeout_err(timeout_err)
   );

   bs_tx_arbiter #(.GAP_CYCLES(0), .START_TIMEOUT(16)) dut0 (
      .clock(clock), .reset_n(reset_n),
      .tok_req(tok_req), .dat_req(dat_req),
      .tok_valid(tok_valid), .tok_bit(tok_bit),
      .dat_valid(dat_valid), .dat_bit(dat_bit),
      .bs_ready(bs_ready), .bs_sending(bs_sending),
      .tok_gnt(tok_gnt_z), .dat_gnt(dat_gnt_z),
      .tok_ready(tok_ready_z), .dat_ready(dat_ready_z),
      .enc5_valid(enc5_valid_z), .enc5_bit(enc5_bit_z),
      .enc16_valid(enc16_valid_z), .enc16_bit(enc16_bit_z),
      .busy(busy_z), .timeout_err(timeout_err_z)
   );

   always #5 clock = ~clock;

   function automatic logic [9:0] outs();
      return {tok_gnt, dat_gnt, tok_ready, dat_ready, enc5_valid, enc5_bit,
              enc16_valid, enc16_bit, busy, timeout_err};
   endfunction

   // Expected {gnts, readies, enc5 pair, enc16 pair} while src holds the grant.
   function automatic logic [7:0] exp_vec(input int src, input logic v, input logic b,
                                          input logic rdy);
      if (src == 0) return {1'b1, 1'b0, rdy, 1'b0, v, b, 1'b0, 1'b0};
      else          return {1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, v, b};
   endfunction

   function automatic int pick(input int rq, input int lw);
      if (rq == 1) return 0;
      if (rq == 2) return 1;
      return 1 - lw;
   endfunction

   task automatic set_src(input int src, input logic v, input logic b);
      if (src == 0) begin tok_valid = v; tok_bit = b; end
      else          begin dat_valid = v; dat_bit = b; end
   endtask

   task automatic set_noise(input int src, input bit on);
      logic nv, nb;
      nv = on ? 1'($urandom_range(0, 1)) : 1'b0;
      nb = on ? 1'($urandom_range(0, 1)) : 1'b0;
      if (src == 0) begin dat_valid = nv; dat_bit = nb; end
      else          begin tok_valid = nv; tok_bit = nb; end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tok_req = 0; dat_req = 0; tok_valid = 0; tok_bit = 0;
      dat_valid = 0; dat_bit = 0; bs_ready = 0; bs_sending = 0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      lw_model = 1;
   endtask

   // Waits for a grant on one instance; exp_n counts negedges after the call.
   task automatic expect_grant(input int src, input int exp_n, input bit on_z,
                               input string name);
      int n;
      bit seen;
      logic [1:0] g;
      n = 0; seen = 0; g = 2'b00;
      while (!seen && n < 40) begin
         @(negedge clock); #2;
         n++;
         g = on_z ? {tok_gnt_z, dat_gnt_z} : {tok_gnt, dat_gnt};
         if (g != 2'b00) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_wait: no grant within %0d cycles", name, n);
      end else begin
         if (n != exp_n) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles want %0d", name, n, exp_n);
         end
         checks++;
         if (g !== ((src == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s_winner: got gnt=%b want %b", name, g,
                     (src == 0) ? 2'b10 : 2'b01);
         end
      end
   endtask

   // Streams nbits from the granted source, then drains; returns in the cycle
   // where bs_sending is first presented low (encoder finished).
   task automatic drive_packet(input int src, input int nbits, input int stall_at,
                               input bit rand_stall, input bit noise, input int tail,
                               input string name);
      int i, cyc;
      bit stalled;
      logic b, rdy;
      logic [9:0] o;
      i = 0; cyc = 0; stalled = 0;
      b = 1'($urandom_range(0, 1));
      while (i < nbits) begin
         @(negedge clock);
         rdy = 1'b1;
         if (i == stall_at && !stalled) begin
            rdy = 1'b0; stalled = 1;
         end else if (rand_stall && $urandom_range(0, 3) == 0) begin
            rdy = 1'b0;
         end
         bs_ready = rdy; bs_sending = 1'b1;
         set_src(src, 1'b1, b);
         set_noise(src, noise);
         if (cyc > 0) begin
            if (src == 0) tok_req = 1'b0; else dat_req = 1'b0;
         end
         #2;
         o = outs();
         checks++;
         if (o[9:2] !== exp_vec(src, 1'b1, b, rdy)) begin
            errors++;
            $display("FAIL %s_bit%0d: got %b want %b", name, i, o[9:2],
                     exp_vec(src, 1'b1, b, rdy));
         end
         if (rdy) begin
            i++;
            b = 1'($urandom_range(0, 1));
         end
         cyc++;
      end
      for (int t = 0; t <= tail; t++) begin
         @(negedge clock);
         bs_ready = 1'b1; bs_sending = 1'b1;
         set_src(src, 1'b0, 1'b0);
         set_noise(src, noise);
         #2;
         o = outs();
         checks++;
         if ({o[9:2], o[1]} !== {exp_vec(src, 1'b0, 1'b0, 1'b1), 1'b1}) begin
            errors++;
            $display("FAIL %s_drain%0d: got %b want %b", name, t, {o[9:2], o[1]},
                     {exp_vec(src, 1'b0, 1'b0, 1'b1), 1'b1});
         end
      end
      @(negedge clock);
      bs_sending = 1'b0;
      set_noise(src, 1'b0);
      #2;
      checks++;
      if ({tok_gnt, dat_gnt} !== ((src == 0) ? 2'b10 : 2'b01)) begin
         errors++;
         $display("FAIL %s_hold_until_idle: got gnt=%b", name, {tok_gnt, dat_gnt});
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tok_req = 1; dat_req = 1; tok_valid = 1; dat_valid = 1; bs_ready = 1;
      tok_bit = 1; dat_bit = 1;
      #1;
      checks++;
      if (outs() !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0", outs());
      end
      do_reset();
      @(negedge clock); #2;
      checks++;
      if (outs() !== 10'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got %b want 0", outs());
      end
   endtask

   task automatic test_tie_then_gap();
      do_reset();
      @(negedge clock);
      tok_req = 1; dat_req = 1;
      expect_grant(0, 1, 0, "tie_first");
      lw_model = 0;
      drive_packet(0, 8, -1, 0, 0, 2, "tok_pkt");
      // dat_req held through gap; granted GAP+1 edges after the fall is sampled
      expect_grant(1, G + 2, 0, "held_dat_after_gap");
      lw_model = 1;
   endtask

   task automatic test_dat_stall();
      do_reset();
      @(negedge clock);
      dat_req = 1;
      expect_grant(1, 1, 0, "dat_only");
      drive_packet(1, 19, 7, 0, 1, 3, "dat19");
   endtask

   task automatic test_abort();
      do_reset();
      @(negedge clock);
      dat_req = 1;
      expect_grant(1, 1, 0, "abort_grant");
      dat_req = 0;
      @(negedge clock); #2;
      checks++;
      if ({tok_gnt, dat_gnt, busy} !== 3'b000) begin
         errors++;
         $display("FAIL abort_to_idle: got %b want 000", {tok_gnt, dat_gnt, busy});
      end
      tok_req = 1;
      expect_grant(0, 1, 0, "abort_no_gap");
      tok_req = 0;
   endtask

   task automatic test_watchdog();
      do_reset();
      @(negedge clock);
      dat_req = 1;
      expect_grant(1, 1, 0, "wd_grant");
      for (int k = 2; k <= 16; k++) begin
         @(negedge clock); #2;
         checks++;
         if ({dat_gnt, timeout_err} !== 2'b10) begin
            errors++;
            $display("FAIL wd_wait%0d: got gnt,err=%b want 10", k, {dat_gnt, timeout_err});
         end
      end
`ifdef BS_ARB_WATCHDOG_EN
      @(negedge clock); #2;
      checks++;
      if ({dat_gnt, timeout_err, busy} !== 3'b011) begin
         errors++;
         $display("FAIL wd_fire: got gnt,err,busy=%b want 011", {dat_gnt, timeout_err, busy});
      end
      dat_req = 0;
      @(negedge clock); #2;
      checks++;
      if ({dat_gnt, timeout_err, busy} !== 3'b001) begin
         errors++;
         $display("FAIL wd_gap2: got gnt,err,busy=%b want 001", {dat_gnt, timeout_err, busy});
      end
      @(negedge clock); #2;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wd_idle: got busy=%b want 0", busy);
      end
`else
      for (int k = 17; k <= 24; k++) begin
         @(negedge clock); #2;
         checks++;
         if ({dat_gnt, timeout_err} !== 2'b10) begin
            errors++;
            $display("FAIL nowd_hold%0d: got gnt,err=%b want 10", k, {dat_gnt, timeout_err});
         end
      end
      dat_req = 0;
      @(negedge clock); #2;
      checks++;
      if ({dat_gnt, busy} !== 2'b00) begin
         errors++;
         $display("FAIL nowd_release: got gnt,busy=%b want 00", {dat_gnt, busy});
      end
`endif
   endtask

   task automatic test_random();
      int rq, win;
      do_reset();
      @(negedge clock);
      rq = $urandom_range(1, 3);
      tok_req = rq[0]; dat_req = rq[1];
      win = pick(rq, lw_model);
      expect_grant(win, 1, 0, "rnd_first");
      lw_model = win;
      for (int p = 0; p < 25; p++) begin
         if (win == 0) dat_req = 0; else tok_req = 0;
         drive_packet(win, $urandom_range(1, 12), -1, 1, 1, $urandom_range(0, 3), "rnd_pkt");
         rq = $urandom_range(1, 3);
         tok_req = rq[0]; dat_req = rq[1];
         win = pick(rq, lw_model);
         expect_grant(win, G + 2, 0, "rnd_next");
         lw_model = win;
      end
      tok_req = 0; dat_req = 0;
   endtask

   task automatic test_gap0();
      do_reset();
      @(negedge clock);
      tok_req = 1;
      expect_grant(0, 1, 1, "gap0_first");
      drive_packet(0, 5, -1, 0, 0, 1, "gap0_pkt");
      tok_req = 1;
      // zero gap: grant one edge after the edge that samples bs_sending low
      expect_grant(0, 2, 1, "gap0_back_to_back");
      tok_req = 0;
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      @(negedge clock);
      tok_req = 1; dat_req = 1;
      expect_grant(0, 1, 0, "rst_tie");
      dat_req = 0;
      @(negedge clock);
      tok_valid = 1; tok_bit = 1; bs_ready = 1; bs_sending = 1; dat_valid = 1;
      #2;
      checks++;
      if ({enc5_valid, enc5_bit, busy} !== 3'b111) begin
         errors++;
         $display("FAIL rst_pre_stream: got %b want 111", {enc5_valid, enc5_bit, busy});
      end
      @(negedge clock);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 10'b0) begin
         errors++;
         $display("FAIL rst_mid_stream: got %b want 0", outs());
      end
      @(negedge clock);
      tok_req = 0; tok_valid = 0; tok_bit = 0; dat_valid = 0; bs_sending = 0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      tok_req = 1; dat_req = 1;
      expect_grant(0, 1, 0, "rst_tie_after");
      tok_req = 0; dat_req = 0;
   endtask

   initial begin
      test_reset();
      test_tie_then_gap();
      test_dat_stall();
      test_abort();
      test_watchdog();
      test_random();
      test_gap0();
      test_reset_mid_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
